demux_dispatcher: RTL and testbench

Sequencing controller for the 1-to-4 demultiplexer datapath. Accepts data words over a valid/ready input handshake, chooses one of four output channels (round-robin over ready channels, or directed by the requester), and drives the demux select `s` plus a one-hot `out_valid`. A stuck channel times out so the input is never blocked indefinitely. Per-channel delivery counters and a drop counter support bring-up and status readout.

---
 rtl/demux_dispatcher.sv | 138 +++++++++++++
 tb/tb_demux_dispatcher.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatcher.sv
// Dispatch controller for a 1-to-4 demux: captures one word at a time, offers it to a
// round-robin or requester-chosen channel, and drops it if the channel stays stuck.
module demux_dispatcher #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             mode,
    input  logic [1:0]       in_dest,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       cnt0,
    output logic [7:0]       cnt1,
    output logic [7:0]       cnt2,
    output logic [7:0]       cnt3,
    output logic             drop_err,
    output logic [7:0]       drop_cnt,
    output logic             dbg_state
);

    // Handshakes: a word moves on a channel only on a rising edge where valid and ready are both high.
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_s;
    logic [1:0]       r_last;
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_valid;
    logic [WW-1:0]    r_wait;
    logic [7:0]       r_cnt [4];
    logic             r_drop_err;
    logic [7:0]       r_drop_cnt;

    logic             w_capture;
    logic             w_deliver;
    logic             w_timeout;
    logic [1:0]       w_rr_sel;
    logic [1:0]       w_sel;

    assign w_capture = (r_state == ST_IDLE) && in_valid;
    assign w_deliver = (r_state == ST_HOLD) && out_ready[r_s];
    assign w_timeout = (r_state == ST_HOLD) && !out_ready[r_s] && (TIMEOUT != 0)
                       && (r_wait == WAIT_LAST);

    // Scan from the farthest candidate down so the nearest ready channel after r_last wins.
    always_comb begin : rr_search
        logic [1:0] cand;
        w_rr_sel = r_last + 2'd1;
        cand     = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = r_last + 2'(k);
            if (out_ready[cand]) begin
                w_rr_sel = cand;
            end
        end
    end

    assign w_sel = mode ? in_dest : w_rr_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_capture) w_state_nxt = ST_HOLD;
            ST_HOLD: if (w_deliver || w_timeout) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s        <= 2'd0;
            r_last     <= 2'b11;
            r_data     <= '0;
            r_valid    <= 4'b0000;
            r_wait     <= '0;
            r_drop_err <= 1'b0;
            r_drop_cnt <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= 8'd0;
            end
        end else begin
            r_drop_err <= w_timeout;
            if (w_capture) begin
                r_data  <= in_data;
                r_s     <= w_sel;
                r_valid <= 4'b0001 << w_sel;
                r_wait  <= '0;
            end else if (r_state == ST_HOLD) begin
                // Delivery is checked first, so a late out_ready on the final wait cycle still wins.
                if (w_deliver) begin
                    r_valid    <= 4'b0000;
                    r_cnt[r_s] <= r_cnt[r_s] + 8'd1;
                    r_last     <= r_s;
                end else if (w_timeout) begin
                    r_valid    <= 4'b0000;
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                    r_last     <= r_s;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
            end
        end
    end

    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign s         = r_s;
    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign cnt0      = r_cnt[0];
    assign cnt1      = r_cnt[1];
    assign cnt2      = r_cnt[2];
    assign cnt3      = r_cnt[3];
    assign drop_err  = r_drop_err;
    assign drop_cnt  = r_drop_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_demux_dispatcher.sv
// Self-checking bench for demux_dispatcher: round-robin, skip, directed, timeout,
// counter wrap and reset-during-hold scenarios against a scoreboard of expected words.
module tb_demux_dispatcher;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         mode = 1'b0;
    logic [1:0]   in_dest = 2'd0;
    logic [1:0]   s;
    logic [W-1:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready = 4'b0000;
    logic [7:0]   cnt0, cnt1, cnt2, cnt3;
    logic         drop_err;
    logic [7:0]   drop_cnt;
    logic         dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [W+1:0] exp_q[$];
    logic [7:0]   m_cnt [4];
    logic [7:0]   m_drop;

    demux_dispatcher #(.WIDTH(W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .in_dest(in_dest),
        .s(s), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3),
        .drop_err(drop_err), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] cnt_of(input int c);
        case (c)
            0: return cnt0;
            1: return cnt1;
            2: return cnt2;
            default: return cnt3;
        endcase
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic md, input logic [1:0] dest, input logic [W-1:0] data,
                        input logic [3:0] rdy);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL send_wait in_ready=%b expected=1", in_ready);
        end
        in_valid  = 1'b1;
        mode      = md;
        in_dest   = dest;
        in_data   = data;
        out_ready = rdy;
        tick();
        in_valid = 1'b0;
        mode     = 1'($urandom_range(0, 1));
        in_dest  = 2'($urandom_range(0, 3));
        in_data  = W'($urandom_range(0, 255));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_out_valid got=%b exp=0000", out_valid); end
        checks++; if (s !== 2'd0) begin failures++; $display("FAIL reset_s got=%0d exp=0", s); end
        checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if ({cnt0, cnt1, cnt2, cnt3} !== 32'd0) begin failures++; $display("FAIL reset_cnts got=%h exp=0", {cnt0, cnt1, cnt2, cnt3}); end
        checks++; if (drop_err !== 1'b0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop got=%b/%0d exp=0/0", drop_err, drop_cnt); end
        checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
        for (int c = 0; c < 4; c++) m_cnt[c] = 8'd0;
        m_drop = 8'd0;
    endtask

    task automatic test_rr_all_ready();
        int t0;
        logic [1:0] es;
        logic [W+1:0] e, g;
        t0 = cyc;
        for (int i = 0; i < 5; i++) begin
            es = 2'(i);
            exp_q.push_back({es, W'(8'hA0 + i)});
            send(1'b0, 2'd0, W'(8'hA0 + i), 4'b1111);
            checks++; if (out_valid !== (4'b0001 << es)) begin failures++; $display("FAIL rr_valid word=%0d got=%b exp=%b", i, out_valid, 4'b0001 << es); end
            g = {s, out_data}; e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL rr_deliver got s=%0d data=%h exp s=%0d data=%h", g[W+1:W], g[W-1:0], e[W+1:W], e[W-1:0]); end
            m_cnt[es] = m_cnt[es] + 8'd1;
            tick();
        end
        checks++; if (cyc - t0 != 10) begin failures++; $display("FAIL rr_throughput got=%0d cycles exp=10", cyc - t0); end
        checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin failures++; $display("FAIL rr_idle got valid=%b ready=%b exp 0000/1", out_valid, in_ready); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (cnt_of(c) !== m_cnt[c]) begin failures++; $display("FAIL rr_cnt%0d got=%0d exp=%0d", c, cnt_of(c), m_cnt[c]); end
        end
    endtask

    task automatic test_rr_skip();
        logic [W+1:0] e, g;
        exp_q.push_back({2'd2, W'(8'hA5)});
        send(1'b0, 2'd0, W'(8'hA5), 4'b0100);
        checks++; if (out_valid !== 4'b0100) begin failures++; $display("FAIL skip_valid got=%b exp=0100", out_valid); end
        g = {s, out_data}; e = exp_q.pop_front();
        checks++; if (g !== e) begin failures++; $display("FAIL skip_deliver got s=%0d data=%h exp s=%0d data=%h", g[W+1:W], g[W-1:0], e[W+1:W], e[W-1:0]); end
        m_cnt[2] = m_cnt[2] + 8'd1;
        tick();
        exp_q.push_back({2'd3, W'(8'hA6)});
        send(1'b0, 2'd0, W'(8'hA6), 4'b0000);
        checks++; if (out_valid !== 4'b1000) begin failures++; $display("FAIL none_ready_valid got=%b exp=1000", out_valid); end
        out_ready = 4'b1000;
        g = {s, out_data}; e = exp_q.pop_front();
        checks++; if (g !== e) begin failures++; $display("FAIL none_ready_deliver got s=%0d data=%h exp s=%0d data=%h", g[W+1:W], g[W-1:0], e[W+1:W], e[W-1:0]); end
        m_cnt[3] = m_cnt[3] + 8'd1;
        tick();
        out_ready = 4'b0000;
        checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL none_ready_done got=%b exp=0000", out_valid); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (cnt_of(c) !== m_cnt[c]) begin failures++; $display("FAIL skip_cnt%0d got=%0d exp=%0d", c, cnt_of(c), m_cnt[c]); end
        end
    endtask

    task automatic test_directed();
        logic [W+1:0] e, g;
        exp_q.push_back({2'd3, W'(8'h5C)});
        send(1'b1, 2'd3, W'(8'h5C), 4'b0000);
        for (int k = 0; k < 5; k++) begin
            checks++; if (out_valid !== 4'b1000 || out_data !== W'(8'h5C)) begin failures++; $display("FAIL dir_hold cyc=%0d got valid=%b data=%h exp 1000/5c", k, out_valid, out_data); end
            if (k == 4) begin
                out_ready = 4'b1000;
                g = {s, out_data}; e = exp_q.pop_front();
                checks++; if (g !== e) begin failures++; $display("FAIL dir_deliver got s=%0d data=%h exp s=%0d data=%h", g[W+1:W], g[W-1:0], e[W+1:W], e[W-1:0]); end
            end
            tick();
        end
        out_ready = 4'b0000;
        m_cnt[3] = m_cnt[3] + 8'd1;
        checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin failures++; $display("FAIL dir_idle got valid=%b ready=%b exp 0000/1", out_valid, in_ready); end
        checks++; if (cnt3 !== m_cnt[3]) begin failures++; $display("FAIL dir_cnt3 got=%0d exp=%0d", cnt3, m_cnt[3]); end
    endtask

    task automatic test_timeout();
        int n;
        logic [W+1:0] e, g;
        send(1'b0, 2'd0, W'(8'h77), 4'b0000);
        n = 0;
        while (out_valid !== 4'b0000 && n < 40) begin
            n++;
            tick();
        end
        m_drop = m_drop + 8'd1;
        checks++; if (n != 16) begin failures++; $display("FAIL timeout_len got=%0d exp=16", n); end
        checks++; if (drop_err !== 1'b1) begin failures++; $display("FAIL timeout_pulse got=%b exp=1", drop_err); end
        checks++; if (drop_cnt !== m_drop) begin failures++; $display("FAIL timeout_drop_cnt got=%0d exp=%0d", drop_cnt, m_drop); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL timeout_in_ready got=%b exp=1", in_ready); end
        checks++; if (cnt0 !== m_cnt[0]) begin failures++; $display("FAIL timeout_cnt0 got=%0d exp=%0d", cnt0, m_cnt[0]); end
        tick();
        checks++; if (drop_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse_end got=%b exp=0", drop_err); end
        // Late delivery on the last wait cycle
        exp_q.push_back({2'd1, W'(8'h88)});
        send(1'b0, 2'd0, W'(8'h88), 4'b0000);
        repeat (15) tick();
        out_ready = 4'b0010;
        g = {s, out_data}; e = exp_q.pop_front();
        checks++; if (g !== e || out_valid !== 4'b0010) begin failures++; $display("FAIL late_deliver got s=%0d data=%h valid=%b exp s=%0d data=%h valid=0010", g[W+1:W], g[W-1:0], out_valid, e[W+1:W], e[W-1:0]); end
        tick();
        out_ready = 4'b0000;
        m_cnt[1] = m_cnt[1] + 8'd1;
        checks++; if (out_valid !== 4'b0000 || drop_err !== 1'b0) begin failures++; $display("FAIL late_idle got valid=%b drop_err=%b exp 0000/0", out_valid, drop_err); end
        checks++; if (drop_cnt !== m_drop) begin failures++; $display("FAIL late_drop_cnt got=%0d exp=%0d", drop_cnt, m_drop); end
        checks++; if (cnt1 !== m_cnt[1]) begin failures++; $display("FAIL late_cnt1 got=%0d exp=%0d", cnt1, m_cnt[1]); end
    endtask

    task automatic test_wrap();
        int nwords;
        logic [W-1:0] d;
        logic [W+1:0] e, g;
        nwords = 256 - int'(m_cnt[0]);
        for (int i = 0; i < nwords; i++) begin
            d = W'($urandom_range(0, 255));
            exp_q.push_back({2'd0, d});
            send(1'b1, 2'd0, d, 4'b0001);
            g = {s, out_data}; e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL wrap_deliver i=%0d got s=%0d data=%h exp s=%0d data=%h", i, g[W+1:W], g[W-1:0], e[W+1:W], e[W-1:0]); end
            m_cnt[0] = m_cnt[0] + 8'd1;
            tick();
        end
        out_ready = 4'b0000;
        checks++; if (cnt0 !== 8'd0) begin failures++; $display("FAIL wrap_cnt0 got=%0d exp=0", cnt0); end
    endtask

    task automatic test_reset_mid_hold();
        logic [W+1:0] e, g;
        send(1'b0, 2'd0, W'(8'h99), 4'b0000);
        checks++; if (out_valid !== 4'b0010) begin failures++; $display("FAIL midhold_valid got=%b exp=0010", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 4'b0000 || in_ready !== 1'b0) begin failures++; $display("FAIL midhold_reset got valid=%b ready=%b exp 0000/0", out_valid, in_ready); end
        checks++; if ({cnt0, cnt1, cnt2, cnt3, drop_cnt} !== 40'd0) begin failures++; $display("FAIL midhold_counters got=%h exp=0", {cnt0, cnt1, cnt2, cnt3, drop_cnt}); end
        for (int c = 0; c < 4; c++) m_cnt[c] = 8'd0;
        m_drop = 8'd0;
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.push_back({2'd0, W'(8'hB0)});
        send(1'b0, 2'd0, W'(8'hB0), 4'b1111);
        checks++; if (out_valid !== 4'b0001) begin failures++; $display("FAIL post_reset_valid got=%b exp=0001", out_valid); end
        g = {s, out_data}; e = exp_q.pop_front();
        checks++; if (g !== e) begin failures++; $display("FAIL post_reset_deliver got s=%0d data=%h exp s=%0d data=%h", g[W+1:W], g[W-1:0], e[W+1:W], e[W-1:0]); end
        m_cnt[0] = m_cnt[0] + 8'd1;
        tick();
        out_ready = 4'b0000;
        checks++; if (cnt0 !== m_cnt[0] || drop_cnt !== m_drop) begin failures++; $display("FAIL post_reset_cnt got cnt0=%0d drop=%0d exp %0d/%0d", cnt0, drop_cnt, m_cnt[0], m_drop); end
    endtask

    initial begin
        test_reset();
        test_rr_all_ready();
        test_rr_skip();
        test_directed();
        test_timeout();
        test_wrap();
        test_reset_mid_hold();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
